// File: rtl/reorder_queue_n_pkg.sv
// reorder_queue_pkg: shared defaults and tag-distance helper for the reorder queue
package reorder_queue_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_TAG_BITS = 6;
  function automatic int unsigned tag_dist(int unsigned t, int unsigned h, int unsigned tag_bits);
    return (t - h) & ((32'd1 << tag_bits) - 32'd1);
  endfunction
endpackage

// File: rtl/reorder_queue_n_if.sv
// reorder_queue_n_if: requester/responder/consumer bundle; master drives alloc, wr_*, stall; slave returns alloc_tag, full, q, valid, count, err
interface reorder_queue_n_if
  import reorder_queue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_BITS = DEF_TAG_BITS
);
  logic                alloc;
  logic [TAG_BITS-1:0] alloc_tag;
  logic                full;
  logic                wr_en;
  logic [TAG_BITS-1:0] wr_tag;
  logic [WIDTH-1:0]    wr_data;
  logic [WIDTH-1:0]    q;
  logic                valid;
  logic                stall;
  logic [TAG_BITS:0]   count;
  logic                err;
  modport master (output alloc, wr_en, wr_tag, wr_data, stall,
                  input alloc_tag, full, q, valid, count, err);
  modport slave (input alloc, wr_en, wr_tag, wr_data, stall,
                 output alloc_tag, full, q, valid, count, err);
endinterface

// File: rtl/reorder_queue_n_mem.sv
// reorder_queue_mem: DEPTH x WIDTH dual-port RAM; wr_* synchronous write port, rd_addr_i/rd_data_o asynchronous read
module reorder_queue_mem #(
  parameter int WIDTH = 8,
  parameter int TAG_BITS = 6
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [TAG_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]    wr_data_i,
  input  logic [TAG_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]    rd_data_o
);
  logic [WIDTH-1:0] mem_q [2**TAG_BITS];
  always_ff @(posedge clk)
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/reorder_queue_n.sv
// reorder_queue_n: in-order completion buffer; clk, async active-low rst_n, bus (slave) carries alloc/write/output/status
module reorder_queue_n
  import reorder_queue_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_BITS = DEF_TAG_BITS
) (
  input logic              clk,
  input logic              rst_n,
  reorder_queue_n_if.slave bus
);
  localparam int DEPTH = 2**TAG_BITS;
  logic [TAG_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_BITS:0]   count_q, count_d;
  logic [DEPTH-1:0]    done_q, done_d;
  logic [WIDTH-1:0]    q_q, q_d, rd_data;
  logic                valid_q, valid_d, err_q, err_d;
  logic                full, alloc_take, retire, wr_ok;
  assign full       = count_q == (TAG_BITS+1)'(DEPTH);
  assign alloc_take = bus.alloc && !full;
  assign retire     = done_q[head_q] && count_q != '0 && (!valid_q || !bus.stall);
  // done is the registered vector, so a write to a head retiring this edge is rejected
  assign wr_ok      = bus.wr_en && !done_q[bus.wr_tag] &&
                      tag_dist(32'(bus.wr_tag), 32'(head_q), 32'(TAG_BITS)) < 32'(count_q);
  assign tail_d  = tail_q + TAG_BITS'(alloc_take);
  assign head_d  = head_q + TAG_BITS'(retire);
  assign count_d = count_q + (TAG_BITS+1)'(alloc_take) - (TAG_BITS+1)'(retire);
  assign valid_d = retire || (valid_q && bus.stall);
  assign q_d     = retire ? rd_data : q_q;
  assign err_d   = err_q || (bus.wr_en && !wr_ok);
  always_comb begin
    done_d = done_q;
    if (retire) done_d[head_q] = 1'b0;
    if (wr_ok) done_d[bus.wr_tag] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
      q_q     <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  reorder_queue_mem #(.WIDTH(WIDTH), .TAG_BITS(TAG_BITS)) u_mem (
    .clk      (clk),
    .wr_en_i  (wr_ok),
    .wr_addr_i(bus.wr_tag),
    .wr_data_i(bus.wr_data),
    .rd_addr_i(head_q),
    .rd_data_o(rd_data)
  );
  assign bus.alloc_tag = tail_q;
  assign bus.full      = full;
  assign bus.q         = q_q;
  assign bus.valid     = valid_q;
  assign bus.count     = count_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_reorder_queue_n.sv
// tb_reorder_queue_n: directed table-driven bench for reorder_queue_n (64-entry and 4-entry instances)
module tb_reorder_queue_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  reorder_queue_n_if #(.WIDTH(8), .TAG_BITS(6)) b1 ();
  reorder_queue_n_if #(.WIDTH(8), .TAG_BITS(2)) b2 ();
  reorder_queue_n #(.WIDTH(8), .TAG_BITS(6)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  reorder_queue_n #(.WIDTH(8), .TAG_BITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  typedef struct {
    logic       alloc;
    logic       wr_en;
    logic [5:0] wr_tag;
    logic [7:0] wr_data;
    logic       stall;
    logic       e_valid;
    logic [7:0] e_q;
    logic [6:0] e_count;
    logic       e_err;
    logic [5:0] e_tag;
  } vec_t;
  vec_t tv [26];
  int total = 0;
  int passed = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic a, input logic w, input logic [5:0] t, input logic [7:0] d, input logic s);
    b1.alloc = a;
    b1.wr_en = w;
    b1.wr_tag = t;
    b1.wr_data = d;
    b1.stall = s;
    step();
  endtask
  function automatic vec_t mk(input logic a, input logic w, input logic [5:0] t, input logic [7:0] d, input logic s,
                              input logic ev, input logic [7:0] eq, input logic [6:0] ec, input logic ee, input logic [5:0] et);
    vec_t v;
    v.alloc = a; v.wr_en = w; v.wr_tag = t; v.wr_data = d; v.stall = s;
    v.e_valid = ev; v.e_q = eq; v.e_count = ec; v.e_err = ee; v.e_tag = et;
    return v;
  endfunction
  initial begin
    tv[0]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1);
    tv[1]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 2, 0, 2);
    tv[2]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 3, 0, 3);
    tv[3]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 3, 0, 3);
    tv[4]  = mk(0, 1, 2, 8'h02, 0, 1, 8'h00, 2, 0, 3);
    tv[5]  = mk(0, 1, 1, 8'h01, 0, 0, 8'h00, 2, 0, 3);
    tv[6]  = mk(0, 0, 0, 8'h00, 0, 1, 8'h01, 1, 0, 3);
    tv[7]  = mk(0, 0, 0, 8'h00, 0, 1, 8'h02, 0, 0, 3);
    tv[8]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 3);
    tv[9]  = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0, 4);
    tv[10] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 2, 0, 5);
    tv[11] = mk(1, 1, 3, 8'hA3, 0, 0, 8'h00, 3, 0, 6);
    tv[12] = mk(0, 1, 4, 8'hA4, 1, 1, 8'hA3, 2, 0, 6);
    tv[13] = mk(0, 1, 5, 8'hA5, 1, 1, 8'hA3, 2, 0, 6);
    tv[14] = mk(0, 0, 0, 8'h00, 1, 1, 8'hA3, 2, 0, 6);
    tv[15] = mk(0, 0, 0, 8'h00, 1, 1, 8'hA3, 2, 0, 6);
    tv[16] = mk(0, 0, 0, 8'h00, 1, 1, 8'hA3, 2, 0, 6);
    tv[17] = mk(0, 0, 0, 8'h00, 1, 1, 8'hA3, 2, 0, 6);
    tv[18] = mk(0, 0, 0, 8'h00, 0, 1, 8'hA4, 1, 0, 6);
    tv[19] = mk(0, 0, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 6);
    tv[20] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 6);
    tv[21] = mk(0, 1, 5, 8'hEE, 0, 0, 8'h00, 0, 1, 6);
    tv[22] = mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 7);
    tv[23] = mk(0, 1, 6, 8'h66, 0, 0, 8'h00, 1, 1, 7);
    tv[24] = mk(0, 1, 6, 8'h77, 0, 1, 8'h66, 0, 1, 7);
    tv[25] = mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 7);
    b1.alloc = 0; b1.wr_en = 0; b1.wr_tag = '0; b1.wr_data = '0; b1.stall = 0;
    b2.alloc = 0; b2.wr_en = 0; b2.wr_tag = '0; b2.wr_data = '0; b2.stall = 0;
    step();
    step();
    chk("rst_valid", 32'(b1.valid), 0);
    chk("rst_count", 32'(b1.count), 0);
    chk("rst_err", 32'(b1.err), 0);
    chk("rst_full", 32'(b1.full), 0);
    chk("rst_tag", 32'(b1.alloc_tag), 0);
    chk("rst_q", 32'(b1.q), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      drive(tv[i].alloc, tv[i].wr_en, tv[i].wr_tag, tv[i].wr_data, tv[i].stall);
      chk($sformatf("v%0d_valid", i), 32'(b1.valid), 32'(tv[i].e_valid));
      chk($sformatf("v%0d_count", i), 32'(b1.count), 32'(tv[i].e_count));
      chk($sformatf("v%0d_err", i), 32'(b1.err), 32'(tv[i].e_err));
      chk($sformatf("v%0d_tag", i), 32'(b1.alloc_tag), 32'(tv[i].e_tag));
      if (tv[i].e_valid) chk($sformatf("v%0d_q", i), 32'(b1.q), 32'(tv[i].e_q));
    end
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 8'h00, 0);
    drive(0, 1, 7, 8'h5A, 0);
    drive(0, 0, 0, 8'h00, 0);
    chk("pre_rst_valid", 32'(b1.valid), 1);
    chk("pre_rst_count", 32'(b1.count), 3);
    chk("pre_rst_q", 32'(b1.q), 32'h5A);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(b1.valid), 0);
    chk("arst_count", 32'(b1.count), 0);
    chk("arst_err", 32'(b1.err), 0);
    chk("arst_q", 32'(b1.q), 0);
    chk("arst_tag", 32'(b1.alloc_tag), 0);
    chk("arst_full", 32'(b1.full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("fill_tag%0d", i), 32'(b1.alloc_tag), 32'(i));
      chk($sformatf("fill_full%0d", i), 32'(b1.full), 0);
      drive(1, 0, 0, 8'h00, 0);
    end
    chk("full_set", 32'(b1.full), 1);
    chk("full_count", 32'(b1.count), 64);
    drive(1, 0, 0, 8'h00, 0);
    chk("full_ignored_count", 32'(b1.count), 64);
    chk("full_ignored_tag", 32'(b1.alloc_tag), 0);
    chk("full_ignored_full", 32'(b1.full), 1);
    b1.alloc = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrap_tag%0d", i), 32'(b2.alloc_tag), 32'(i % 4));
      b2.alloc = 1;
      step();
      b2.alloc = 0;
      b2.wr_en = 1;
      b2.wr_tag = 2'(i % 4);
      b2.wr_data = 8'(8'h10 + i);
      step();
      b2.wr_en = 0;
      step();
      chk($sformatf("wrap_valid%0d", i), 32'(b2.valid), 1);
      chk($sformatf("wrap_q%0d", i), 32'(b2.q), 32'(8'h10 + i));
      chk($sformatf("wrap_count%0d", i), 32'(b2.count), 0);
      chk($sformatf("wrap_err%0d", i), 32'(b2.err), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/reorder_queue_n.md
# reorder_queue_n

Parametrised in-order completion buffer for out-of-order responders. A requester allocates sequential tags, responders return data tagged in any order, and the block releases data strictly in allocation order through a valid/stall output register. Generalises the fixed 8-bit/64-entry reorder queue with:
- parametrised width and depth;
- explicit write tags;
- an occupancy count;
- error detection for illegal writes.

## Interface
Parameters:
- WIDTH, 8, payload bits.
- TAG_BITS, 6, tag width; DEPTH = 2**TAG_BITS entries.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- alloc  in  1  request next tag this cycle.
- alloc_tag  out  TAG_BITS  tag granted when alloc && !full.
- full  out  1  all DEPTH tags outstanding; alloc ignored.
- wr_en  in  1  responder write strobe.
- wr_tag  in  TAG_BITS  tag being completed.
- wr_data  in  WIDTH  payload for wr_tag.
- q  out  WIDTH  in-order payload.
- valid  out  1  q holds an entry.
- stall  in  1  consumer not ready; q/valid hold.
- count  out  TAG_BITS+1  tags outstanding, excluding the output register.
- err  out  1  sticky illegal-write flag.

## Operation
- State:
  - tail pointer `tail` (next tag to grant);
  - head pointer `head` (next tag to retire);
  - `count`, 0..DEPTH;
  - DEPTH-bit done vector;
  - DEPTH x WIDTH storage;
  - output register (q, valid).
- alloc_tag = tail. full = (count == DEPTH).
- Allocate: if alloc && !full, tail <= tail+1 (mod DEPTH) and the tag becomes outstanding.
- Outstanding test: tag t is outstanding iff ((t - head) mod DEPTH) < count.
- Write, legal case: wr_en, tag outstanding, done[wr_tag] == 0 → mem[wr_tag] <= wr_data, done[wr_tag] <= 1.
- Write, illegal case: wr_en with a non-outstanding tag or done already set → write dropped, err <= 1. err stays set until reset.
- Retire condition: done[head] && count != 0 && (!valid || !stall). When it holds:
  - q <= mem[head], valid <= 1;
  - done[head] <= 0, head <= head+1;
  - the slot is freed.
- Drain: if valid && !stall and no retire is possible, valid <= 0. q keeps its old value (don't-care).
- count next = count + alloc_taken − retire. Simultaneous alloc and retire leaves count unchanged.
- No flush. Reset is the only way to abandon outstanding tags.

## Timing
- Reset (rst low, async): tail=0, head=0, count=0, done=0, valid=0, q=0, err=0, full=0, alloc_tag=0. Storage is not reset.
- Reset deassertion is synchronised externally. The first legal operation is the first edge with rst high.
- alloc/full/alloc_tag: full is derived from registered count. An alloc in the cycle count reaches DEPTH is refused, even if a retire occurs in the same cycle.
- Write-to-output latency: wr_en sampled at edge k for tag == head, output register free → valid high after edge k+1. The done bit becomes visible at k; the output register loads at k+1.
- Back-to-back throughput: with head entries already complete and stall low, one entry retires per cycle.
- Stall: while valid && stall, q and valid are stable and nothing retires. A consumed entry (valid && !stall) may be replaced at the same edge.
- Wrap-around: tail and head wrap at DEPTH. Tag 0 is reissued after tag DEPTH−1 once it has retired.
- Write to head in the same cycle head retires: illegal, because done[head] is already set → err.
- Write and allocate of the same tag in one cycle: illegal, because the tag is not yet outstanding → err.

## Structure
- Shared package/header `reorder_queue_pkg` holds:
  - default WIDTH/TAG_BITS;
  - the helper that computes tag distance (t − head) mod DEPTH.
- Sub-module `reorder_queue_mem`: simple dual-port RAM, DEPTH x WIDTH.
  - Write port driven by the responder.
  - Asynchronous read at head, registered into q by the top level.
  - Maps onto distributed RAM.
- The done vector, pointers, count and output register live in the top level.

## Test plan
- In-order fill (WIDTH=8, TAG_BITS=6): allocate until full, then stop alloc.
  - full rises with count=64 after the 64th grant.
  - alloc_tag sequence is 0..63.
  - A further alloc is ignored.
- Reordered completion: allocate tags 0,1,2; write tag 0=0x00, tag 2=0x02, tag 1=0x01 on consecutive cycles.
  - q sequence 0x00, 0x01, 0x02, with valid gaps matching the 2-cycle write-to-output latency.
- Stall hold: stall held high for 5 cycles with 3 completed entries.
  - q stays at the first value; count stays constant.
  - After release, three consecutive valid cycles.
- Illegal writes: write to a non-allocated tag 5; then write tag 0 twice.
  - err sets on the first illegal write and stays 1.
  - Stored data and q are unaffected.
- Wrap-around with TAG_BITS=2: run 10 alloc/write/retire rounds.
  - Tags cycle 0,1,2,3,0…
  - Output order matches allocation order; count never exceeds 4.
- Async reset mid-operation: assert rst low with valid=1, count=3.
  - All outputs reach their reset values without a clock edge.
  - After release, the next grant is tag 0.
